// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//
// Shares one single-ported synchronous SRAM between the instruction-fetch
// requester and the data (load/store) requester of the 5-stage pipeline.
// At most one access is granted per cycle. Data wins ties unless fetch has
// been denied MAX_STARVE cycles in a row, in which case fetch is forced
// ahead. Read data comes back from the SRAM one cycle after the grant and
// is steered to whichever requester issued the read.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   inst_req/inst_addr            fetch read request (held until inst_ack)
//   inst_ack                      fetch accepted this cycle (combinational)
//   inst_rvalid/inst_rdata        fetch response, one cycle after inst_ack
//   data_req/data_wr/data_wstrb/
//   data_addr/data_wdata          load/store request (held until data_ack)
//   data_ack                      data accepted this cycle (combinational)
//   data_rvalid/data_rdata        load response, one cycle after data_ack
//   sram_en/sram_wen/sram_addr/
//   sram_wdata/sram_rdata         single-ported SRAM interface
//   conflict_cnt                  saturating count of cycles with both requests
module sram_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_STARVE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_req,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    output logic                  inst_ack,
    output logic                  inst_rvalid,
    output logic [DATA_WIDTH-1:0] inst_rdata,
    input  logic                  data_req,
    input  logic                  data_wr,
    input  logic [3:0]            data_wstrb,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0] data_wdata,
    output logic                  data_ack,
    output logic                  data_rvalid,
    output logic [DATA_WIDTH-1:0] data_rdata,
    output logic                  sram_en,
    output logic [3:0]            sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output logic [31:0]           conflict_cnt
);

    localparam logic [2:0] MaxStarve = 3'(MAX_STARVE);

    typedef enum logic [1:0] {
        RESP_NONE,
        RESP_INST,
        RESP_DATA
    } resp_e;

    resp_e       resp_sel_q, resp_sel_d;
    logic [2:0]  starve_q, starve_d;
    logic [31:0] conflict_q, conflict_d;
    logic        force_inst;
    logic        grant_inst;
    logic        grant_data;

    assign force_inst = (starve_q == MaxStarve);

    // Grant selection and SRAM drive. Data wins a tie unless fetch has been
    // starved long enough to be forced through. Nothing is granted in reset.
    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (!rst) begin
            if (inst_req && (!data_req || force_inst)) begin
                grant_inst = 1'b1;
            end else if (data_req) begin
                grant_data = 1'b1;
            end
        end

        sram_en    = grant_inst | grant_data;
        sram_addr  = grant_inst ? inst_addr : data_addr;
        sram_wen   = (grant_data && data_wr) ? data_wstrb : 4'b0000;
        sram_wdata = data_wdata;
    end

    assign inst_ack = grant_inst;
    assign data_ack = grant_data;

    // Next-state for the in-flight tag, the starvation counter and the
    // conflict counter. Stores leave nothing in flight. The starvation
    // counter only grows while fetch is actually waiting behind data.
    always_comb begin
        resp_sel_d = RESP_NONE;
        if (grant_inst) begin
            resp_sel_d = RESP_INST;
        end else if (grant_data && !data_wr) begin
            resp_sel_d = RESP_DATA;
        end

        starve_d = starve_q;
        if (grant_inst || !inst_req) begin
            starve_d = 3'd0;
        end else if (grant_data && (starve_q < MaxStarve)) begin
            starve_d = starve_q + 3'd1;
        end

        conflict_d = conflict_q;
        if (inst_req && data_req && (conflict_q != 32'hFFFF_FFFF)) begin
            conflict_d = conflict_q + 32'd1;
        end
    end

    // State registers; reset also drops any read still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_sel_q <= RESP_NONE;
            starve_q   <= 3'd0;
            conflict_q <= 32'd0;
        end else begin
            resp_sel_q <= resp_sel_d;
            starve_q   <= starve_d;
            conflict_q <= conflict_d;
        end
    end

    // The response valid is masked while reset is held so a read issued just
    // before reset never surfaces.
    assign inst_rvalid  = (resp_sel_q == RESP_INST) && !rst;
    assign data_rvalid  = (resp_sel_q == RESP_DATA) && !rst;
    assign inst_rdata   = sram_rdata;
    assign data_rdata   = sram_rdata;
    assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
//
// Directed scenarios plus a randomized run of sram_port_arbiter, compared
// against a behavioural model of the arbitration rules kept in this file.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_sram_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MS = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic          inst_ack;
    logic          inst_rvalid;
    logic [DW-1:0] inst_rdata;
    logic          data_req;
    logic          data_wr;
    logic [3:0]    data_wstrb;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic          data_ack;
    logic          data_rvalid;
    logic [DW-1:0] data_rdata;
    logic          sram_en;
    logic [3:0]    sram_wen;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;
    logic [31:0]   conflict_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: denial streak, conflict total, and which requester
    // (0 none, 1 fetch, 2 load) gets the SRAM data in the coming cycle.
    int     m_starve;
    longint m_conflict;
    int     m_pend;

    sram_port_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MAX_STARVE(MS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .inst_req(inst_req),
        .inst_addr(inst_addr),
        .inst_ack(inst_ack),
        .inst_rvalid(inst_rvalid),
        .inst_rdata(inst_rdata),
        .data_req(data_req),
        .data_wr(data_wr),
        .data_wstrb(data_wstrb),
        .data_addr(data_addr),
        .data_wdata(data_wdata),
        .data_ack(data_ack),
        .data_rvalid(data_rvalid),
        .data_rdata(data_rdata),
        .sram_en(sram_en),
        .sram_wen(sram_wen),
        .sram_addr(sram_addr),
        .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Who the rules say wins this cycle, given the current requests.
    function automatic void model_grant(output bit gi, output bit gd);
        gi = 1'b0;
        gd = 1'b0;
        if (!rst) begin
            if (inst_req && data_req) begin
                if (m_starve >= MS) gi = 1'b1;
                else                gd = 1'b1;
            end else if (inst_req) begin
                gi = 1'b1;
            end else if (data_req) begin
                gd = 1'b1;
            end
        end
    endfunction

    // Cross one rising edge and bring the model forward with it.
    task automatic advance();
        bit gi, gd;
        model_grant(gi, gd);
        @(posedge clk);
        if (rst) begin
            m_starve   = 0;
            m_conflict = 0;
            m_pend     = 0;
        end else begin
            if (inst_req && data_req && m_conflict < 64'hFFFF_FFFF) m_conflict++;
            m_pend = gi ? 1 : ((gd && !data_wr) ? 2 : 0);
            if (gi || !inst_req) m_starve = 0;
            else if (gd)         m_starve = (m_starve + 1 > MS) ? MS : m_starve + 1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        inst_req = 1'b1;
        data_req = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++;
            if ({inst_ack, data_ack, sram_en, sram_wen} !== 7'b0) begin
                n_fail++;
                $display("[TB] FAIL reset_grant: got ack/en/wen %b expected 0", {inst_ack, data_ack, sram_en, sram_wen});
            end
            advance();
        end
        rst = 1'b0;
        inst_req = 1'b0;
        data_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            n_checks++;
            if ({inst_ack, data_ack, sram_en, inst_rvalid, data_rvalid} !== 5'b0 || conflict_cnt !== 32'd0) begin
                n_fail++;
                $display("[TB] FAIL reset_idle: got ack/en/rvalid %b cnt %0d expected 0 and 0",
                         {inst_ack, data_ack, sram_en, inst_rvalid, data_rvalid}, conflict_cnt);
            end
            advance();
        end
    endtask

    task automatic test_fetch();
        inst_req  = 1'b1;
        inst_addr = 32'hbfc0_0000;
        #1;
        n_checks++;
        if (inst_ack !== 1'b1 || sram_en !== 1'b1 || sram_addr !== 32'hbfc0_0000 || sram_wen !== 4'b0) begin
            n_fail++;
            $display("[TB] FAIL fetch_issue: got ack %b en %b addr %h wen %b expected 1 1 bfc00000 0000",
                     inst_ack, sram_en, sram_addr, sram_wen);
        end
        advance();
        inst_req   = 1'b0;
        sram_rdata = 32'h2408_0001;
        #1;
        n_checks++;
        if (inst_rvalid !== 1'b1 || inst_rdata !== 32'h2408_0001 || data_rvalid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL fetch_resp: got rvalid %b rdata %h data_rvalid %b expected 1 24080001 0",
                     inst_rvalid, inst_rdata, data_rvalid);
        end
        advance();
    endtask

    task automatic test_store();
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_wstrb = 4'b0011;
        data_addr  = 32'h10;
        data_wdata = 32'hdead_beef;
        #1;
        n_checks++;
        if (data_ack !== 1'b1 || inst_ack !== 1'b0 || sram_en !== 1'b1 || sram_wen !== 4'b0011 ||
            sram_addr !== 32'h10 || sram_wdata !== 32'hdead_beef) begin
            n_fail++;
            $display("[TB] FAIL store_issue: got ack %b en %b wen %b addr %h wdata %h expected 1 1 0011 10 deadbeef",
                     data_ack, sram_en, sram_wen, sram_addr, sram_wdata);
        end
        advance();
        data_req = 1'b0;
        data_wr  = 1'b0;
        #1;
        n_checks++;
        if (data_rvalid !== 1'b0 || inst_rvalid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL store_no_rvalid: got rvalid %b/%b expected 0/0", inst_rvalid, data_rvalid);
        end
        advance();
    endtask

    // Both requesters hold their request for ten cycles: fetch must break
    // through on every fifth cycle and the responses must follow one behind.
    task automatic test_conflict();
        longint base;
        bit exp_i, exp_ri;
        advance();
        base      = m_conflict;
        inst_req  = 1'b1;
        inst_addr = 32'h0000_0400;
        data_req  = 1'b1;
        data_wr   = 1'b0;
        data_addr = 32'h0000_0800;
        for (int k = 0; k <= 10; k++) begin
            if (k == 10) begin
                inst_req = 1'b0;
                data_req = 1'b0;
            end
            #1;
            if (k < 10) begin
                exp_i = (k % 5 == 4);
                n_checks++;
                if (inst_ack !== exp_i || data_ack !== !exp_i) begin
                    n_fail++;
                    $display("[TB] FAIL conflict_grant c%0d: got inst/data ack %b%b expected %b%b",
                             k, inst_ack, data_ack, exp_i, !exp_i);
                end
            end
            if (k > 0) begin
                exp_ri = ((k - 1) % 5 == 4);
                n_checks++;
                if (inst_rvalid !== exp_ri || data_rvalid !== !exp_ri) begin
                    n_fail++;
                    $display("[TB] FAIL conflict_rvalid c%0d: got inst/data rvalid %b%b expected %b%b",
                             k, inst_rvalid, data_rvalid, exp_ri, !exp_ri);
                end
            end
            advance();
        end
        #1;
        n_checks++;
        if (64'(conflict_cnt) !== base + 10) begin
            n_fail++;
            $display("[TB] FAIL conflict_count: got %0d expected %0d", conflict_cnt, base + 10);
        end
    endtask

    // Build up fetch starvation, issue a load, then reset on the response
    // cycle: the load data must vanish and the denial streak must restart.
    task automatic test_reset_inflight();
        inst_req = 1'b1;
        data_req = 1'b1;
        data_wr  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++;
            if (data_ack !== 1'b1 || inst_ack !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL rstfl_pre c%0d: got inst/data ack %b%b expected 01", k, inst_ack, data_ack);
            end
            advance();
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (data_rvalid !== 1'b0 || {inst_ack, data_ack, sram_en} !== 3'b0) begin
            n_fail++;
            $display("[TB] FAIL rstfl_during: got rvalid %b ack/en %b expected 0 000", data_rvalid, {inst_ack, data_ack, sram_en});
        end
        advance();
        rst = 1'b0;
        #1;
        n_checks++;
        if (data_rvalid !== 1'b0 || inst_rvalid !== 1'b0 || data_ack !== 1'b1 || inst_ack !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rstfl_after: got rvalid %b%b ack %b%b expected 00 01",
                     inst_rvalid, data_rvalid, inst_ack, data_ack);
        end
        advance();
        data_req = 1'b0;
        #1;
        n_checks++;
        if (inst_ack !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rstfl_fetch: got inst_ack %b expected 1", inst_ack);
        end
        advance();
        inst_req = 1'b0;
        advance();
    endtask

    task automatic test_saturation();
        longint exp_c;
        force dut.conflict_q = 32'hFFFF_FFFD;
        #1;
        release dut.conflict_q;
        m_conflict = 64'hFFFF_FFFD;
        inst_req = 1'b1;
        data_req = 1'b1;
        data_wr  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            exp_c = 64'hFFFF_FFFD + k;
            if (exp_c > 64'hFFFF_FFFF) exp_c = 64'hFFFF_FFFF;
            n_checks++;
            if (64'(conflict_cnt) !== exp_c) begin
                n_fail++;
                $display("[TB] FAIL saturate c%0d: got %h expected %h", k, conflict_cnt, exp_c[31:0]);
            end
            advance();
        end
        inst_req = 1'b0;
        data_req = 1'b0;
        advance();
    endtask

    // Random traffic obeying the hold-until-ack rule, with occasional resets.
    task automatic test_random();
        bit gi, gd;
        for (int c = 0; c < 500; c++) begin
            rst = ($urandom_range(0, 79) == 0);
            if (!inst_req && $urandom_range(0, 2) != 0) begin
                inst_req  = 1'b1;
                inst_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!data_req && $urandom_range(0, 2) != 0) begin
                data_req   = 1'b1;
                data_wr    = 1'($urandom_range(0, 1));
                data_wstrb = 4'($urandom_range(0, 15));
                data_addr  = $urandom;
                data_wdata = $urandom;
            end
            sram_rdata = $urandom;
            #1;
            model_grant(gi, gd);
            n_checks++;
            if (inst_ack !== gi || data_ack !== gd || sram_en !== (gi | gd)) begin
                n_fail++;
                $display("[TB] FAIL rand_grant c%0d: got ack %b%b en %b expected %b%b %b",
                         c, inst_ack, data_ack, sram_en, gi, gd, gi | gd);
            end
            n_checks++;
            if (sram_wen !== ((gd && data_wr) ? data_wstrb : 4'b0)) begin
                n_fail++;
                $display("[TB] FAIL rand_wen c%0d: got %b expected %b", c, sram_wen, (gd && data_wr) ? data_wstrb : 4'b0);
            end
            if (gi || gd) begin
                n_checks++;
                if (sram_addr !== (gi ? inst_addr : data_addr) || (gd && data_wr && sram_wdata !== data_wdata)) begin
                    n_fail++;
                    $display("[TB] FAIL rand_drive c%0d: got addr %h wdata %h expected addr %h wdata %h",
                             c, sram_addr, sram_wdata, gi ? inst_addr : data_addr, data_wdata);
                end
            end
            n_checks++;
            if (inst_rvalid !== (m_pend == 1 && !rst) || data_rvalid !== (m_pend == 2 && !rst)) begin
                n_fail++;
                $display("[TB] FAIL rand_rvalid c%0d: got %b%b expected %b%b", c, inst_rvalid, data_rvalid,
                         (m_pend == 1 && !rst), (m_pend == 2 && !rst));
            end
            if (m_pend != 0 && !rst) begin
                n_checks++;
                if ((m_pend == 1 ? inst_rdata : data_rdata) !== sram_rdata) begin
                    n_fail++;
                    $display("[TB] FAIL rand_rdata c%0d: got %h expected %h", c,
                             (m_pend == 1) ? inst_rdata : data_rdata, sram_rdata);
                end
            end
            n_checks++;
            if (64'(conflict_cnt) !== m_conflict) begin
                n_fail++;
                $display("[TB] FAIL rand_count c%0d: got %0d expected %0d", c, conflict_cnt, m_conflict);
            end
            advance();
            if (gi) inst_req = 1'b0;
            if (gd) data_req = 1'b0;
        end
        rst      = 1'b0;
        inst_req = 1'b0;
        data_req = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        inst_req   = 1'b0;
        inst_addr  = '0;
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_wstrb = 4'b0;
        data_addr  = '0;
        data_wdata = '0;
        sram_rdata = '0;
        m_starve   = 0;
        m_conflict = 0;
        m_pend     = 0;
        @(negedge clk);
        test_reset();
        test_fetch();
        test_store();
        test_conflict();
        test_reset_inflight();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-ported synchronous SRAM between the instruction-fetch requester and the data (load/store) requester of the 5-stage MIPS pipeline.
- Per cycle it grants at most one access. Data has priority, and a starvation guard protects fetch.
- It tracks the in-flight read and returns SRAM read data, one cycle later, to the requester that issued it.
- It sits between mycpu_top's fetch/MEM stages and the unified SRAM; the pipeline stalls on missing ack.

Parameters:
ADDR_WIDTH, 32, SRAM byte-address width
DATA_WIDTH, 32, SRAM data width
MAX_STARVE, 4, consecutive fetch denials tolerated before fetch is forced ahead of data (legal 1..7)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
inst_req  in  1  fetch read request (level, held until acked)
inst_addr  in  ADDR_WIDTH  fetch address
inst_ack  out  1  fetch request accepted this cycle (combinational)
inst_rvalid  out  1  inst_rdata valid (registered)
inst_rdata  out  DATA_WIDTH  fetched word
data_req  in  1  data access request (level, held until acked)
data_wr  in  1  1=store, 0=load
data_wstrb  in  4  byte enables for store
data_addr  in  ADDR_WIDTH  data address
data_wdata  in  DATA_WIDTH  store data
data_ack  out  1  data request accepted this cycle (combinational)
data_rvalid  out  1  data_rdata valid, loads only (registered)
data_rdata  out  DATA_WIDTH  load word
sram_en  out  1  SRAM enable
sram_wen  out  4  SRAM byte write enables
sram_addr  out  ADDR_WIDTH  SRAM address
sram_wdata  out  DATA_WIDTH  SRAM write data
sram_rdata  in  DATA_WIDTH  SRAM read data, valid cycle after read issue
conflict_cnt  out  32  count of cycles with both requests pending (saturating)

Behaviour:
Clock and reset:
- Single clock clk.
- rst is synchronous and active-high; it is the only reset.

Grant rule (combinational, per cycle):
- Define force_inst = (starve_cnt == MAX_STARVE).
- inst_req only: grant inst.
- data_req only: grant data.
- Both pending, force_inst=0: grant data.
- Both pending, force_inst=1: grant inst.
- Neither pending: no grant; sram_en=0, sram_wen=0.
- While rst=1: acks=0, sram_en=0, sram_wen=0.

SRAM drive:
- Granted port's address drives sram_addr; sram_en=1.
- Store grant: sram_wen=data_wstrb, sram_wdata=data_wdata.
- Any read grant: sram_wen=0.
- When idle, sram_addr/sram_wdata are don't-care.

In-flight state (resp_sel register):
- States: NONE, INST_RD, DATA_RD.
- Next state is INST_RD on an inst grant, DATA_RD on a data load grant, NONE otherwise (including store grant).
- Response cycle:
  - inst_rvalid = (resp_sel==INST_RD).
  - data_rvalid = (resp_sel==DATA_RD).
  - Both rdata outputs = sram_rdata (combinational passthrough).
- Read latency is exactly 1 cycle after ack; stores produce no rvalid.
- Back-to-back grants every cycle are legal; a new issue and the prior response coexist in the same cycle.

Starvation counter (starve_cnt, 3 bits):
- Cleared to 0 when inst is granted or inst_req=0.
- Incremented when inst_req=1 and data is granted.
- Never exceeds MAX_STARVE.

conflict_cnt:
- Increments when inst_req & data_req.
- Saturates at 0xFFFFFFFF.

Reset values and mid-operation reset:
- Reset values: resp_sel=NONE, starve_cnt=0, conflict_cnt=0, inst_rvalid=0, data_rvalid=0.
- rst asserted while a read is in flight: the response is discarded; no rvalid in the cycle after rst.

Requester obligations:
- Requesters keep req and payload stable until ack.
- The arbiter does not buffer requests.

Test Plan:
- Reset, no requests → sram_en=0, all acks and rvalids 0, conflict_cnt=0 for 10 cycles.
- inst_req alone, addr 0xbfc00000, sram_rdata=0x24080001 next cycle → inst_ack=1 cycle 0, inst_rvalid=1 with rdata 0x24080001 cycle 1, data_rvalid=0.
- Store: data_req, data_wr=1, wstrb=0011, addr 0x10, wdata 0xdeadbeef → data_ack=1, sram_wen=0011, sram_wdata=0xdeadbeef, no rvalid next cycle.
- Both requests held continuously, MAX_STARVE=4:
  - Data granted cycles 0-3, inst granted cycle 4, data cycles 5-8, inst cycle 9.
  - conflict_cnt=10 after 10 cycles.
  - rvalids alternate correctly.
- Load granted, rst asserted next cycle → data_rvalid stays 0; after rst released, starve_cnt=0 and fetch granted on first inst_req.
- conflict_cnt preset-forced near 0xFFFFFFFF with both requests held → value holds at 0xFFFFFFFF, no wrap.
